// File: rtl/vstream_pkg.sv
// Shared types and constants for the video stream receiver:
// FSM state encoding, error-bit positions and default frame geometry.
package vstream_pkg;

  localparam int IMG_ROW_DEF = 224;
  localparam int IMG_COL_DEF = 224;
  localparam int WIDTH_D_DEF = 24;

  localparam int ERR_W      = 3;
  localparam int ERR_SHORT  = 0;
  localparam int ERR_TRUNC  = 1;
  localparam int ERR_ORPHAN = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/vstream_rx_if.sv
// Pixel stream bundle (vsync/hsync/valid/tdata) from the image loader.
// The loader drives it through master; the receiver samples it through slave.
interface vstream_rx_if #(
  parameter int WIDTH_D = 24
);
  logic               vsync;
  logic               hsync;
  logic               valid;
  logic [WIDTH_D-1:0] tdata;

  modport master (output vsync, hsync, valid, tdata);
  modport slave  (input  vsync, hsync, valid, tdata);
endinterface

// File: rtl/vstream_pos_cnt.sv
// Row/column/linear-address counters for the receiver. Clear and line-close
// are resolved first, so a beat in the same cycle lands on the new position.
module vstream_pos_cnt #(
  parameter int IMG_ROW = 224,
  parameter int IMG_COL = 224,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              close_i,
  input  logic              inc_i,
  output logic              col_zero_o,
  output logic              last_row_o,
  output logic [7:0]        beat_col_o,
  output logic [7:0]        beat_row_o,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic              beat_last_col_o,
  output logic              beat_last_row_o
);

  localparam logic [7:0]        COL_LAST = 8'(IMG_COL - 1);
  localparam logic [7:0]        ROW_LAST = 8'(IMG_ROW - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(IMG_COL);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [7:0]        col_q,  col_d,  col_b;
  logic [7:0]        row_q,  row_d,  row_b;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_b;
  // base_q tracks row*IMG_COL so a short line can jump to the next stride
  logic [ADDR_W-1:0] base_q, base_d, base_b;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    col_b  = col_q;
    row_b  = row_q;
    addr_b = addr_q;
    base_b = base_q;
    if (clr_i) begin
      col_b  = '0;
      row_b  = '0;
      addr_b = '0;
      base_b = '0;
    end else if (close_i) begin
      col_b  = '0;
      row_b  = row_q + 8'd1;
      addr_b = base_q + STRIDE;
      base_b = base_q + STRIDE;
    end

    col_d  = col_b;
    row_d  = row_b;
    addr_d = addr_b;
    base_d = base_b;
    if (inc_i) begin
      if (col_b == COL_LAST) begin
        col_d = '0;
        if (row_b == ROW_LAST) begin
          row_d  = '0;
          addr_d = '0;
          base_d = '0;
        end else begin
          row_d  = row_b + 8'd1;
          addr_d = addr_b + ADDR_ONE;
          base_d = base_b + STRIDE;
        end
      end else begin
        col_d  = col_b + 8'd1;
        addr_d = addr_b + ADDR_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      base_q <= base_d;
    end
  end

  assign col_zero_o      = (col_q == '0);
  assign last_row_o      = (row_q == ROW_LAST);
  assign beat_col_o      = col_b;
  assign beat_row_o      = row_b;
  assign beat_addr_o     = addr_b;
  assign beat_last_col_o = (col_b == COL_LAST);
  assign beat_last_row_o = (row_b == ROW_LAST);

endmodule

// File: rtl/vstream_rx.sv
// Video stream receiver: decodes frame/line boundaries, emits a registered
// pixel write strobe with row/col/address, and keeps sticky framing errors.
module vstream_rx
  import vstream_pkg::*;
#(
  parameter int WIDTH_D = WIDTH_D_DEF,
  parameter int IMG_ROW = IMG_ROW_DEF,
  parameter int IMG_COL = IMG_COL_DEF,
  parameter int ADDR_W  = 16
) (
  input  logic               i_sclk,
  input  logic               i_rstn,
  vstream_rx_if.slave        s_vid,
  input  logic               i_err_clr,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [WIDTH_D-1:0] o_wr_data,
  output logic [7:0]         o_row,
  output logic [7:0]         o_col,
  output logic               o_line_done,
  output logic               o_frame_done,
  output logic [7:0]         o_frame_cnt,
  output logic [ERR_W-1:0]   o_err
);

  state_e             state_q, state_d;
  logic               hsync_q;
  logic               hs_edge;
  logic               cnt_clr, cnt_close, cnt_inc;
  logic               col_zero, last_row;
  logic [7:0]         beat_col, beat_row;
  logic [ADDR_W-1:0]  beat_addr;
  logic               beat_last_col, beat_last_row;
  logic               line_done_d, frame_done_d;
  logic [7:0]         frame_cnt_d;
  logic [ERR_W-1:0]   err_set;

  logic               wr_en_q, line_done_q, frame_done_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [WIDTH_D-1:0] wr_data_q;
  logic [7:0]         row_q, col_q, frame_cnt_q;
  logic [ERR_W-1:0]   err_q;

  assign hs_edge = s_vid.hsync & ~hsync_q;

  vstream_pos_cnt #(
    .IMG_ROW (IMG_ROW),
    .IMG_COL (IMG_COL),
    .ADDR_W  (ADDR_W)
  ) u_pos (
    .clk             (i_sclk),
    .rst_n           (i_rstn),
    .clr_i           (cnt_clr),
    .close_i         (cnt_close),
    .inc_i           (cnt_inc),
    .col_zero_o      (col_zero),
    .last_row_o      (last_row),
    .beat_col_o      (beat_col),
    .beat_row_o      (beat_row),
    .beat_addr_o     (beat_addr),
    .beat_last_col_o (beat_last_col),
    .beat_last_row_o (beat_last_row)
  );

  // Event priority: vsync, then hsync edge, then the valid beat.
  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_close    = 1'b0;
    cnt_inc      = 1'b0;
    err_set      = '0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (s_vid.vsync) begin
          cnt_clr = 1'b1;
          cnt_inc = s_vid.valid;
          state_d = ST_ACTIVE;
        end else if (s_vid.valid) begin
          err_set[ERR_ORPHAN] = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (s_vid.vsync) begin
          err_set[ERR_TRUNC] = 1'b1;
          cnt_clr            = 1'b1;
          cnt_inc            = s_vid.valid;
        end else if (hs_edge && !col_zero) begin
          err_set[ERR_SHORT] = 1'b1;
          if (last_row) begin
            // Closing the last row ends the frame; a coincident beat has no row to land in
            cnt_clr             = 1'b1;
            state_d             = ST_IDLE;
            err_set[ERR_ORPHAN] = s_vid.valid;
          end else begin
            cnt_close = 1'b1;
            cnt_inc   = s_vid.valid;
          end
        end else begin
          cnt_inc = s_vid.valid;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cnt_inc && beat_last_col) begin
      line_done_d = 1'b1;
      if (beat_last_row) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        state_d      = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      hsync_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      hsync_q      <= s_vid.hsync;
      wr_en_q      <= cnt_inc;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= (err_q & ~{ERR_W{i_err_clr}}) | err_set;
      if (cnt_inc) begin
        wr_addr_q <= beat_addr;
        wr_data_q <= s_vid.tdata;
        row_q     <= beat_row;
        col_q     <= beat_col;
      end
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_row        = row_q;
  assign o_col        = col_q;
  assign o_line_done  = line_done_q;
  assign o_frame_done = frame_done_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_err        = err_q;

endmodule
